// File: rtl/coin_pkg.sv
// coin_pkg: shared definitions for the coin bus.
//   - 2-bit coin codes placed on the coin bus (shared with the vending controller)
//   - step values of each coin, in 5-unit steps
//   - dispenser FSM state encoding
package coin_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_20   = 2'b11;

  localparam logic [2:0] STEP_5  = 3'd1;
  localparam logic [2:0] STEP_10 = 3'd2;
  localparam logic [2:0] STEP_20 = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_SEND   = 2'd2,
    ST_DONE   = 2'd3
  } disp_state_e;

endpackage

// File: rtl/coin_select.sv
// coin_select: combinational greedy coin picker.
//   rem_i   : remaining amount in 5-unit steps
//   code_o  : largest coin code whose value fits in rem_i (COIN_NONE if rem_i == 0)
//   step_o  : step value of code_o (0 if rem_i == 0)
//   zero_o  : rem_i == 0, nothing left to pay
module coin_select
  import coin_pkg::*;
#(
  parameter int AMT_W = 6
) (
  input  logic [AMT_W-1:0] rem_i,
  output logic [1:0]       code_o,
  output logic [2:0]       step_o,
  output logic             zero_o
);

  always_comb begin
    code_o = COIN_NONE;
    step_o = 3'd0;
    zero_o = 1'b0;
    if (rem_i >= AMT_W'(STEP_20)) begin
      code_o = COIN_20;
      step_o = STEP_20;
    end else if (rem_i >= AMT_W'(STEP_10)) begin
      code_o = COIN_10;
      step_o = STEP_10;
    end else if (rem_i >= AMT_W'(STEP_5)) begin
      code_o = COIN_5;
      step_o = STEP_5;
    end else begin
      zero_o = 1'b1;
    end
  end

endmodule

// File: rtl/coin_dispenser.sv
// coin_dispenser: emits a payout as a sequence of coins on the 2-bit coin bus,
// largest coin first, each held until the hopper acknowledges it.
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_amount : payout request (amount in 5-unit steps)
//   req_ready            : high only in IDLE
//   coin_out/coin_valid  : current coin code, valid until coin_ack
//   coin_ack             : hopper took the current coin (only honoured in SEND)
//   busy, done, err      : not-IDLE, completion pulse, timeout-abort pulse
//   coins_sent           : coins acknowledged in the current/last transaction
// Optional feature: define COIN_DISP_TIMEOUT_EN to abort a SEND that waits
// TIMEOUT_CYC cycles without coin_ack; otherwise err is tied low.
module coin_dispenser
  import coin_pkg::*;
#(
  parameter int AMT_W       = 6,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  output logic [1:0]       coin_out,
  output logic             coin_valid,
  input  logic             coin_ack,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AMT_W-1:0] coins_sent
);

  disp_state_e      state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [1:0]       coin_q, coin_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;

  logic [1:0]       sel_code;
  logic [2:0]       sel_step;
  logic             sel_zero;

  // rem_q is unchanged throughout SEND, so the picker's step output during
  // SEND is exactly the value of the coin currently on the bus.
  coin_select #(.AMT_W(AMT_W)) u_sel (
    .rem_i  (rem_q),
    .code_o (sel_code),
    .step_o (sel_step),
    .zero_o (sel_zero)
  );

`ifdef COIN_DISP_TIMEOUT_EN
  localparam int WAIT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    coin_d  = coin_q;
    cnt_d   = cnt_q;
`ifdef COIN_DISP_TIMEOUT_EN
    wait_d  = wait_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rem_d   = req_amount;
          cnt_d   = '0;
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (sel_zero) begin
          state_d = ST_DONE;
        end else begin
          coin_d  = sel_code;
          state_d = ST_SEND;
`ifdef COIN_DISP_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
      end
      ST_SEND: begin
        if (coin_ack) begin
          rem_d   = rem_q - AMT_W'(sel_step);
          cnt_d   = cnt_q + 1'b1;
          coin_d  = COIN_NONE;
          state_d = ST_SELECT;
        end
`ifdef COIN_DISP_TIMEOUT_EN
        // Abort at the end of the TIMEOUT_CYC-th unacknowledged SEND cycle;
        // err is seen in the following cycle, already in IDLE.
        else if (wait_q == WAIT_W'(TIMEOUT_CYC - 1)) begin
          coin_d  = COIN_NONE;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wait_d  = wait_q + 1'b1;
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      coin_q  <= COIN_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      coin_q  <= coin_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef COIN_DISP_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign coin_valid = (state_q == ST_SEND);
  assign done       = (state_q == ST_DONE);
  assign coin_out   = coin_q;
  assign coins_sent = cnt_q;

endmodule

// File: tb/tb_coin_dispenser.sv
module tb_coin_dispenser;
  localparam int AMT_W = 6;
`ifdef COIN_DISP_TIMEOUT_EN
  localparam int TO_CYC = 10;
`else
  localparam int TO_CYC = 255;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic [AMT_W-1:0] req_amount;
  logic             req_ready;
  logic [1:0]       coin_out;
  logic             coin_valid;
  logic             coin_ack;
  logic             busy, done, err;
  logic [AMT_W-1:0] coins_sent;

  int checks = 0;
  int failures = 0;

  coin_dispenser #(.AMT_W(AMT_W), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_amount (req_amount),
    .req_ready  (req_ready),
    .coin_out   (coin_out),
    .coin_valid (coin_valid),
    .coin_ack   (coin_ack),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .coins_sent (coins_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 1);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_valid"}, 32'(coin_valid), 0);
    chk({tag, "_coin"},  32'(coin_out), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_err"},   32'(err), 0);
  endtask

  initial begin
    logic [1:0] seq7 [3];
    seq7[0] = 2'b11; seq7[1] = 2'b10; seq7[2] = 2'b01;

    rst_n = 1'b0; req_valid = 1'b0; req_amount = '0; coin_ack = 1'b0;
    #12;
    chk_idle("rst");
    chk("rst_cnt", 32'(coins_sent), 0);
    #1 rst_n = 1'b1;
    step();
    chk_idle("post_rst");

    // Amount 7, ack held high: 11, 10, 01 every other cycle
    req_valid = 1'b1; req_amount = 6'd7; coin_ack = 1'b1;
    step();
    req_valid = 1'b0;
    chk("a7_sel_busy",  32'(busy), 1);
    chk("a7_sel_ready", 32'(req_ready), 0);
    chk("a7_sel_valid", 32'(coin_valid), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("a7_valid%0d", i), 32'(coin_valid), 1);
      chk($sformatf("a7_coin%0d", i),  32'(coin_out), 32'(seq7[i]));
      step();
      chk($sformatf("a7_gap_valid%0d", i), 32'(coin_valid), 0);
      chk($sformatf("a7_gap_coin%0d", i),  32'(coin_out), 0);
      chk($sformatf("a7_cnt%0d", i),       32'(coins_sent), 32'(i + 1));
    end
    chk("a7_no_done_early", 32'(done), 0);
    step();
    chk("a7_done", 32'(done), 1);
    chk("a7_done_valid", 32'(coin_valid), 0);
    step();
    chk_idle("a7_end");
    chk("a7_cnt", 32'(coins_sent), 3);
    coin_ack = 1'b0;

    // Amount 0: SELECT -> DONE, no coin
    req_valid = 1'b1; req_amount = 6'd0;
    step();
    req_valid = 1'b0;
    chk("a0_sel_valid", 32'(coin_valid), 0);
    chk("a0_sel_done",  32'(done), 0);
    step();
    chk("a0_done",  32'(done), 1);
    chk("a0_valid", 32'(coin_valid), 0);
    chk("a0_cnt",   32'(coins_sent), 0);
    step();
    chk_idle("a0_end");

    // Amount 4, ack after 5 SEND cycles
    req_valid = 1'b1; req_amount = 6'd4;
    step();
    req_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("a4_valid%0d", i), 32'(coin_valid), 1);
      chk($sformatf("a4_coin%0d", i),  32'(coin_out), 3);
      if (i == 4) coin_ack = 1'b1;
      step();
    end
    coin_ack = 1'b0;
    chk("a4_sel_valid", 32'(coin_valid), 0);
    chk("a4_cnt",       32'(coins_sent), 1);
    step();
    chk("a4_done", 32'(done), 1);
    step();
    chk_idle("a4_end");

    // Amount 3, second request (9) mid-transaction must be ignored
    req_valid = 1'b1; req_amount = 6'd3; coin_ack = 1'b1;
    step();
    req_amount = 6'd9;
    chk("a3_ready_busy", 32'(req_ready), 0);
    step();
    chk("a3_coin0", 32'(coin_out), 2);
    chk("a3_valid0", 32'(coin_valid), 1);
    step();
    step();
    chk("a3_coin1", 32'(coin_out), 1);
    chk("a3_ready_send", 32'(req_ready), 0);
    step();
    chk("a3_cnt_sel", 32'(coins_sent), 2);
    step();
    chk("a3_done", 32'(done), 1);
    req_valid = 1'b0; coin_ack = 1'b0;
    step();
    chk_idle("a3_end");
    step();
    chk("a3_not_queued", 32'(busy), 0);
    chk("a3_cnt", 32'(coins_sent), 2);

    // Amount 8, reset asserted mid-SEND
    req_valid = 1'b1; req_amount = 6'd8;
    step();
    req_valid = 1'b0;
    step();
    chk("a8_valid", 32'(coin_valid), 1);
    chk("a8_coin",  32'(coin_out), 3);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("a8_rst");
    chk("a8_rst_cnt", 32'(coins_sent), 0);
    step();
    #2 rst_n = 1'b1;
    step();
    chk_idle("a8_after");

`ifdef COIN_DISP_TIMEOUT_EN
    // Amount 2, never acknowledged: abort after 10 SEND cycles
    req_valid = 1'b1; req_amount = 6'd2;
    step();
    req_valid = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("to_valid%0d", i), 32'(coin_valid), 1);
      chk($sformatf("to_err%0d", i),   32'(err), 0);
      step();
    end
    chk("to_err",   32'(err), 1);
    chk("to_valid", 32'(coin_valid), 0);
    chk("to_coin",  32'(coin_out), 0);
    chk("to_done",  32'(done), 0);
    chk("to_ready", 32'(req_ready), 1);
    chk("to_cnt",   32'(coins_sent), 0);
    step();
    chk("to_err_pulse", 32'(err), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
